// File: rtl/wb_dma_master.sv
// Wishbone classic single-access DMA master.
// Copies len_i words from src to dst, one read/write pair per word.
module wb_dma_master #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [31:0] src_addr_i,
    input  logic [31:0] dst_addr_i,
    input  logic [15:0] len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    input  logic        m_rty_i
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_GAP,
        S_FIN
    } state_t;

    state_t r_state;
    state_t w_state_n;

    logic [31:0]   r_src;
    logic [31:0]   r_dst;
    logic [15:0]   r_cnt;
    logic [31:0]   r_data;
    logic          r_resume_wr;
    logic          r_err;
    logic [TW-1:0] r_tmo;

    logic [31:0]   w_src_n;
    logic [31:0]   w_dst_n;
    logic [15:0]   w_cnt_n;
    logic [31:0]   w_data_n;
    logic          w_resume_n;
    logic          w_err_n;
    logic [TW-1:0] w_tmo_n;

    logic w_active;
    logic w_fail;
    logic w_retry;
    logic w_ack;
    logic w_bus_n;
    logic w_new_acc;

    assign err_o = r_err;

    // Response decode: err beats rty, rty beats ack; silence past the limit is an error.
    always_comb begin
        w_active = (r_state == S_RD) || (r_state == S_WR);
        w_fail   = w_active &&
                   (m_err_i || (!m_rty_i && !m_ack_i && (r_tmo == TMO_LAST)));
        w_retry  = w_active && !m_err_i && m_rty_i;
        w_ack    = w_active && !m_err_i && !m_rty_i && m_ack_i;
    end

    // Next-state and next-datapath logic.
    always_comb begin
        w_state_n  = r_state;
        w_src_n    = r_src;
        w_dst_n    = r_dst;
        w_cnt_n    = r_cnt;
        w_data_n   = r_data;
        w_resume_n = r_resume_wr;
        w_err_n    = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_src_n   = src_addr_i;
                    w_dst_n   = dst_addr_i;
                    w_cnt_n   = len_i;
                    w_err_n   = 1'b0;
                    w_state_n = (len_i == 16'd0) ? S_FIN : S_RD;
                end
            end
            S_RD: begin
                if (w_fail) begin
                    w_err_n   = 1'b1;
                    w_state_n = S_FIN;
                end else if (w_retry) begin
                    w_resume_n = 1'b0;
                    w_state_n  = S_GAP;
                end else if (w_ack) begin
                    w_data_n  = m_dat_i;
                    w_state_n = S_WR;
                end
            end
            S_WR: begin
                if (w_fail) begin
                    w_err_n   = 1'b1;
                    w_state_n = S_FIN;
                end else if (w_retry) begin
                    w_resume_n = 1'b1;
                    w_state_n  = S_GAP;
                end else if (w_ack) begin
                    w_src_n    = r_src + 32'd4;
                    w_dst_n    = r_dst + 32'd4;
                    w_cnt_n    = r_cnt - 16'd1;
                    w_resume_n = 1'b0;
                    w_state_n  = (r_cnt == 16'd1) ? S_FIN : S_GAP;
                end
            end
            S_GAP: begin
                w_resume_n = 1'b0;
                w_state_n  = r_resume_wr ? S_WR : S_RD;
            end
            S_FIN: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        w_bus_n   = (w_state_n == S_RD) || (w_state_n == S_WR);
        w_new_acc = w_bus_n && (w_state_n != r_state);
        if (w_new_acc || !w_bus_n) begin
            w_tmo_n = '0;
        end else begin
            w_tmo_n = r_tmo + TW'(1);
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Address/count/data counters, status and strobe timer.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_resume_wr <= 1'b0;
            r_err       <= 1'b0;
            r_tmo       <= '0;
        end else begin
            r_src       <= w_src_n;
            r_dst       <= w_dst_n;
            r_cnt       <= w_cnt_n;
            r_data      <= w_data_n;
            r_resume_wr <= w_resume_n;
            r_err       <= w_err_n;
            r_tmo       <= w_tmo_n;
        end
    end

    // Registered bus and status outputs, derived from the state being entered.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_sel_o <= 4'h0;
            m_adr_o <= '0;
            m_dat_o <= '0;
        end else begin
            busy_o  <= (w_state_n != S_IDLE);
            done_o  <= (w_state_n == S_FIN);
            m_cyc_o <= w_bus_n;
            m_stb_o <= w_bus_n;
            m_we_o  <= (w_state_n == S_WR);
            m_sel_o <= w_bus_n ? 4'hF : 4'h0;
            m_adr_o <= (w_state_n == S_WR) ? w_dst_n : w_src_n;
            m_dat_o <= w_data_n;
        end
    end

endmodule

// File: tb/tb_wb_dma_master.sv
// Directed bench for wb_dma_master with a transfer-level model
// and a per-cycle bus checker.
module tb_wb_dma_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_i = '0;
    logic [31:0] dst_i = '0;
    logic [15:0] len_i = '0;
    logic        busy_o, done_o, err_o;
    logic [31:0] m_adr_o, m_dat_o, m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_we_o, m_cyc_o, m_stb_o;
    logic        m_ack_i, m_err_i, m_rty_i;

    logic        s_silent = 1'b0;
    logic        s_err_wr = 1'b0;
    logic        s_rty_en = 1'b0;
    logic [31:0] s_rty_adr = '0;
    logic        tb_clr = 1'b0;
    logic        rty_fired = 1'b0;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } acc_t;

    acc_t exp_q[$];

    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int cyc_cnt = 0;

    int          gap_st = 0;
    int          rty_st = 0;
    logic        err_pend = 1'b0;
    logic [31:0] rty_adr_sv;
    logic        rty_we_sv;

    wb_dma_master #(.ACK_TIMEOUT(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .start_i    (start),
        .src_addr_i (src_i),
        .dst_addr_i (dst_i),
        .len_i      (len_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .m_adr_o    (m_adr_o),
        .m_dat_o    (m_dat_o),
        .m_dat_i    (m_dat_i),
        .m_sel_o    (m_sel_o),
        .m_we_o     (m_we_o),
        .m_cyc_o    (m_cyc_o),
        .m_stb_o    (m_stb_o),
        .m_ack_i    (m_ack_i),
        .m_err_i    (m_err_i),
        .m_rty_i    (m_rty_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Zero-wait slave with optional one-shot retry, write error or silence.
    always_comb begin
        m_ack_i = m_cyc_o && m_stb_o && !s_silent;
        m_err_i = m_cyc_o && m_stb_o && s_err_wr && m_we_o;
        m_rty_i = m_cyc_o && m_stb_o && s_rty_en && !rty_fired &&
                  !m_we_o && (m_adr_o == s_rty_adr);
        m_dat_i = (m_cyc_o && m_stb_o && !m_we_o) ? rd_data(m_adr_o) : 32'h0;
    end

    always @(posedge clk) begin
        if (tb_clr) rty_fired <= 1'b0;
        else if (m_cyc_o && m_stb_o && m_rty_i) rty_fired <= 1'b1;
    end

    // Per-cycle checker against the expected access list and bus rules.
    always @(negedge clk) begin
        if (rst) begin
            gap_st = 0;
            rty_st = 0;
            err_pend = 1'b0;
        end else begin
            chk("cyc_eq_stb", 32'(m_cyc_o), 32'(m_stb_o));
            if (m_cyc_o) begin
                cyc_cnt++;
                chk("busy_in_cyc", 32'(busy_o), 32'd1);
                chk("sel", 32'(m_sel_o), 32'hF);
            end
            if (done_o) begin
                done_cnt++;
                chk("done_busy", 32'(busy_o), 32'd1);
                chk("done_nocyc", 32'(m_cyc_o), 32'd0);
            end
            if (gap_st == 1) begin
                chk("gap_low", 32'(m_cyc_o), 32'd0);
                chk("gap_busy", 32'(busy_o), 32'd1);
                gap_st = 2;
            end else if (gap_st == 2) begin
                chk("gap_resume", 32'(m_cyc_o), 32'd1);
                gap_st = 0;
            end
            if (rty_st == 1) begin
                chk("rty_drop", 32'(m_cyc_o), 32'd0);
                rty_st = 2;
            end else if (rty_st == 2) begin
                chk("rty_reissue", 32'(m_cyc_o), 32'd1);
                chk("rty_adr", m_adr_o, rty_adr_sv);
                chk("rty_we", 32'(m_we_o), 32'(rty_we_sv));
                rty_st = 0;
            end
            if (err_pend) begin
                chk("err_drop", 32'(m_cyc_o), 32'd0);
                chk("err_flag", 32'(err_o), 32'd1);
                err_pend = 1'b0;
            end
            if (m_cyc_o && m_stb_o) begin
                if (m_err_i) begin
                    err_pend = 1'b1;
                end else if (m_rty_i) begin
                    rty_st = 1;
                    rty_adr_sv = m_adr_o;
                    rty_we_sv = m_we_o;
                end else if (m_ack_i) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL extra_access: got adr %h want none", m_adr_o);
                    end else begin
                        acc_t e;
                        e = exp_q.pop_front();
                        chk("acc_we", 32'(m_we_o), 32'(e.we));
                        chk("acc_adr", m_adr_o, e.adr);
                        if (e.we) chk("acc_dat", m_dat_o, e.dat);
                        if (e.we && exp_q.size() > 0) gap_st = 1;
                    end
                end
            end
        end
    end

    task automatic load_model(input logic [31:0] s, input logic [31:0] d,
                              input int n_acc);
        exp_q.delete();
        for (int k = 0; k < n_acc; k++) begin
            acc_t e;
            logic [31:0] off;
            off = 32'((k / 2) * 4);
            if (k % 2 == 0) begin
                e.we = 1'b0; e.adr = s + off; e.dat = '0;
            end else begin
                e.we = 1'b1; e.adr = d + off; e.dat = rd_data(s + off);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic run(input string nm, input logic [31:0] s,
                       input logic [31:0] d, input logic [15:0] l,
                       input int exp_lat, input logic exp_err,
                       input int n_acc, input bit spoil);
        int n;
        int d0;
        int c0;
        load_model(s, d, n_acc);
        d0 = done_cnt;
        c0 = cyc_cnt;
        @(negedge clk);
        src_i = s; dst_i = d; len_i = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({nm, "_err_clr"}, 32'(err_o), 32'd0);
                if (spoil) begin
                    src_i = 32'hDEAD0000; dst_i = 32'hBEEF0000;
                    len_i = 16'd7; start = 1'b1;
                end
            end
            if (n == 2) start = 1'b0;
            if (done_o) break;
            if (n >= 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s_timeout: got no done want done", nm);
                break;
            end
        end
        start = 1'b0;
        chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
        chk({nm, "_err"}, 32'(err_o), 32'(exp_err));
        repeat (3) @(negedge clk);
        chk({nm, "_done1"}, 32'(done_cnt - d0), 32'd1);
        chk({nm, "_left"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_idle"}, 32'(busy_o), 32'd0);
        chk({nm, "_err_hold"}, 32'(err_o), 32'(exp_err));
        if (l == 16'd0) chk({nm, "_nocyc"}, 32'(cyc_cnt - c0), 32'd0);
    endtask

    initial begin
        int d0;
        int w;
        repeat (2) @(negedge clk);
        chk("rst_cyc", 32'(m_cyc_o), 32'd0);
        chk("rst_stb", 32'(m_stb_o), 32'd0);
        chk("rst_we", 32'(m_we_o), 32'd0);
        chk("rst_sel", 32'(m_sel_o), 32'd0);
        chk("rst_adr", m_adr_o, 32'd0);
        chk("rst_dat", m_dat_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run("copy", 32'h00000100, 32'h20000200, 16'd3, 9, 1'b0, 6, 1'b0);
        run("len0", 32'h00000040, 32'h00000080, 16'd0, 1, 1'b0, 0, 1'b0);

        @(negedge clk);
        tb_clr = 1'b1;
        s_rty_en = 1'b1;
        s_rty_adr = 32'h00000104;
        @(negedge clk);
        tb_clr = 1'b0;
        run("retry", 32'h00000100, 32'h20000200, 16'd3, 11, 1'b0, 6, 1'b0);
        s_rty_en = 1'b0;

        s_err_wr = 1'b1;
        run("werr", 32'h00000100, 32'h00000300, 16'd3, 3, 1'b1, 1, 1'b0);
        s_err_wr = 1'b0;

        s_silent = 1'b1;
        run("tmo", 32'h00000500, 32'h00000600, 16'd2, 5, 1'b1, 0, 1'b0);
        s_silent = 1'b0;

        load_model(32'h00000700, 32'h00000800, 6);
        d0 = done_cnt;
        @(negedge clk);
        src_i = 32'h00000700; dst_i = 32'h00000800; len_i = 16'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        w = 0;
        while (!(m_we_o && m_cyc_o) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("rst_mid_wr_seen", 32'(m_we_o && m_cyc_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_cyc", 32'(m_cyc_o), 32'd0);
        chk("arst_stb", 32'(m_stb_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("arst_nodone", 32'(done_cnt - d0), 32'd0);

        run("post_rst", 32'h00001000, 32'h00002000, 16'd1, 3, 1'b0, 2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
